dbus_sram_bridge: RTL and testbench

Bridges the naive_mips CPU data bus (`dbus_*`) to one external 16-bit asynchronous SRAM (AS7C34098A-class). It sits directly downstream of the CPU in place of the single-cycle `mem` model and splits each 32-bit word access into up to two halfword SRAM cycles with programmable wait states. It holds the CPU with `dbus_stall` until the access completes.

---
 rtl/dbus_sram_bridge_pkg.sv | 25 ++
 rtl/dbus_sram_bridge.sv | 169 ++++++++++++++++
 tb/tb_dbus_sram_bridge.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/dbus_sram_bridge_pkg.sv
// rtl/dbus_sram_bridge_pkg.sv - shared types and helpers for the dbus to SRAM bridge
//
// Purpose : FSM state encoding, halfword-select constants and the phase
//           counter width helper used by dbus_sram_bridge.
// Ports   : none (package).

package sram_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      DONE = 2'd3
   } sram_state_t;

   // Value of the SRAM halfword address LSB for each phase.
   localparam logic HALF_LO = 1'b0;
   localparam logic HALF_HI = 1'b1;

   // Counter must hold 0..wait_cycles (the last value is the hold cycle).
   function automatic int phase_cnt_w(input int wait_cycles);
      return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
   endfunction

endpackage

// File: rtl/dbus_sram_bridge.sv
// rtl/dbus_sram_bridge.sv - CPU data bus to 16-bit asynchronous SRAM bridge
//
// Purpose : Splits each 32-bit dbus access into up to two halfword SRAM
//           cycles (LO then HI) with WAIT_CYCLES strobe cycles plus one hold
//           cycle per phase, stalling the CPU until the access completes.
// Ports   : clk, rst_n                      - clock, async active-low reset
//           dbus_address/byteenable/read/write/wrdata - CPU request
//           dbus_rddata, dbus_stall         - CPU response
//           sram_addr, sram_data_o/_i/_oe   - SRAM address and data bus
//           sram_ce_n/oe_n/we_n/lb_n/ub_n   - SRAM strobes, registered

module dbus_sram_bridge
   import sram_bridge_pkg::*;
#(
   parameter int ADDR_W      = 18,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       dbus_address,
   input  logic [3:0]        dbus_byteenable,
   input  logic              dbus_read,
   input  logic              dbus_write,
   input  logic [31:0]       dbus_wrdata,
   output logic [31:0]       dbus_rddata,
   output logic              dbus_stall,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [15:0]       sram_data_o,
   input  logic [15:0]       sram_data_i,
   output logic              sram_data_oe,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   output logic              sram_lb_n,
   output logic              sram_ub_n
);

   localparam int            CW       = phase_cnt_w(WAIT_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES);

   sram_state_t       state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-2:0] waddr_q, waddr_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              phase_end;

   // Next values of the registered SRAM pins.
   logic              in_phase;
   logic              half_d;
   logic [ADDR_W-1:0] sram_addr_d;
   logic [15:0]       sram_data_o_d;
   logic              sram_data_oe_d;
   logic              sram_ce_n_d, sram_oe_n_d, sram_we_n_d;
   logic              sram_lb_n_d, sram_ub_n_d;

   logic              addr_unused;
   assign addr_unused = ^{dbus_address[31:ADDR_W+1], dbus_address[1:0]};

   // Gated by rst_n so the CPU is released while the bridge is held in reset.
   assign dbus_stall = rst_n && (dbus_read || dbus_write) && (state_q != DONE);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wr_d      = wr_q;
      waddr_d   = waddr_q;
      be_d      = be_q;
      wdata_d   = wdata_q;
      phase_end = (cnt_q == CNT_LAST);

      unique case (state_q)
         IDLE: begin
            if (dbus_read || dbus_write) begin
               wr_d    = dbus_write;
               waddr_d = dbus_address[ADDR_W:2];
               be_d    = dbus_byteenable;
               wdata_d = dbus_wrdata;
               cnt_d   = '0;
               if (|dbus_byteenable[1:0])      state_d = LO;
               else if (|dbus_byteenable[3:2]) state_d = HI;
               else                            state_d = DONE;
            end
         end
         LO: begin
            if (phase_end) begin
               cnt_d   = '0;
               state_d = (|be_q[3:2]) ? HI : DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         HI: begin
            if (phase_end) begin
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Pins are computed from the next state so that they are flopped and
      // line up exactly with the phase cycles; ce_n/oe_n stay low across LO->HI.
      in_phase       = (state_d == LO) || (state_d == HI);
      half_d         = (state_d == HI) ? HALF_HI : HALF_LO;
      sram_ce_n_d    = !in_phase;
      sram_oe_n_d    = !(in_phase && !wr_d);
      sram_we_n_d    = !(in_phase && wr_d && (cnt_d != CNT_LAST));
      sram_data_oe_d = in_phase && wr_d;
      sram_lb_n_d    = in_phase ? !(half_d ? be_d[2] : be_d[0]) : 1'b1;
      sram_ub_n_d    = in_phase ? !(half_d ? be_d[3] : be_d[1]) : 1'b1;
      sram_addr_d    = in_phase ? {waddr_d, half_d} : sram_addr;
      sram_data_o_d  = (in_phase && wr_d) ? (half_d ? wdata_d[31:16] : wdata_d[15:0])
                                          : sram_data_o;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         wr_q         <= 1'b0;
         waddr_q      <= '0;
         be_q         <= '0;
         wdata_q      <= '0;
         dbus_rddata  <= '0;
         sram_addr    <= '0;
         sram_data_o  <= '0;
         sram_data_oe <= 1'b0;
         sram_ce_n    <= 1'b1;
         sram_oe_n    <= 1'b1;
         sram_we_n    <= 1'b1;
         sram_lb_n    <= 1'b1;
         sram_ub_n    <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         wr_q         <= wr_d;
         waddr_q      <= waddr_d;
         be_q         <= be_d;
         wdata_q      <= wdata_d;
         sram_addr    <= sram_addr_d;
         sram_data_o  <= sram_data_o_d;
         sram_data_oe <= sram_data_oe_d;
         sram_ce_n    <= sram_ce_n_d;
         sram_oe_n    <= sram_oe_n_d;
         sram_we_n    <= sram_we_n_d;
         sram_lb_n    <= sram_lb_n_d;
         sram_ub_n    <= sram_ub_n_d;

         // Capture on the edge closing a read phase; a half with no enabled
         // lanes is zeroed at the same edge so the word is complete in DONE.
         if (!wr_q && phase_end) begin
            if (state_q == LO) begin
               dbus_rddata[15:0] <= sram_data_i;
               if (!(|be_q[3:2])) dbus_rddata[31:16] <= '0;
            end
            if (state_q == HI) begin
               dbus_rddata[31:16] <= sram_data_i;
               if (!(|be_q[1:0])) dbus_rddata[15:0] <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_dbus_sram_bridge.sv
// tb/tb_dbus_sram_bridge.sv - self-checking bench for dbus_sram_bridge

module tb_dbus_sram_bridge;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] addr = '0;
   logic [3:0]  be = '0;
   logic        rd = 1'b0, wr = 1'b0, rd2 = 1'b0;
   logic [31:0] wdata = '0;

   logic [31:0] rddata, rddata2;
   logic        stall, stall2;
   logic [17:0] sram_addr, sram2_addr;
   logic [15:0] s_do, s_di, s2_di, unused2_do;
   logic        s_oe, ce_n, oe_n, we_n, lb_n, ub_n;
   logic        unused2_oe, ce2_n, oe2_n, unused2_we, unused2_lb, unused2_ub;

   dbus_sram_bridge #(.ADDR_W(18), .WAIT_CYCLES(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .dbus_address(addr), .dbus_byteenable(be), .dbus_read(rd), .dbus_write(wr),
      .dbus_wrdata(wdata), .dbus_rddata(rddata), .dbus_stall(stall),
      .sram_addr(sram_addr), .sram_data_o(s_do), .sram_data_i(s_di), .sram_data_oe(s_oe),
      .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n), .sram_lb_n(lb_n), .sram_ub_n(ub_n)
   );

   dbus_sram_bridge #(.ADDR_W(18), .WAIT_CYCLES(3)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .dbus_address(addr), .dbus_byteenable(be), .dbus_read(rd2), .dbus_write(1'b0),
      .dbus_wrdata(wdata), .dbus_rddata(rddata2), .dbus_stall(stall2),
      .sram_addr(sram2_addr), .sram_data_o(unused2_do), .sram_data_i(s2_di),
      .sram_data_oe(unused2_oe), .sram_ce_n(ce2_n), .sram_oe_n(oe2_n),
      .sram_we_n(unused2_we), .sram_lb_n(unused2_lb), .sram_ub_n(unused2_ub)
   );

   // SRAM models: byte-lane writes on clock edges while we_n is low.
   logic [15:0] mem  [0:255];
   logic [15:0] mem2 [0:255];
   assign s_di  = (!ce_n  && !oe_n)  ? mem[sram_addr[7:0]]   : 16'hDEAD;
   assign s2_di = (!ce2_n && !oe2_n) ? mem2[sram2_addr[7:0]] : 16'hDEAD;

   always @(posedge clk) begin
      if (!ce_n && !we_n && s_oe) begin
         if (!lb_n) mem[sram_addr[7:0]][7:0]  <= s_do[7:0];
         if (!ub_n) mem[sram_addr[7:0]][15:8] <= s_do[15:8];
      end
   end

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   int          n_stall, n_ce, n_oe, n_we;
   logic        seen_lo, seen_hi;
   logic [17:0] lo_addr, hi_addr;
   logic [15:0] lo_data, hi_data;
   logic [1:0]  lo_lanes, hi_lanes;
   logic [31:0] done_rd;

   task automatic access(input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d);
      @(negedge clk);
      addr = a; be = b; wdata = d; wr = w; rd = !w;
      n_stall = 0; n_ce = 0; n_oe = 0; n_we = 0; seen_lo = 0; seen_hi = 0;
      lo_addr = '0; hi_addr = '0; lo_data = '0; hi_data = '0; lo_lanes = 2'b11; hi_lanes = 2'b11;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (!stall) break;
         n_stall++;
         if (!ce_n) n_ce++;
         if (!oe_n) n_oe++;
         if (!we_n) n_we++;
         if (!ce_n && !sram_addr[0] && !seen_lo) begin
            seen_lo = 1; lo_addr = sram_addr; lo_data = s_do; lo_lanes = {ub_n, lb_n};
         end
         if (!ce_n && sram_addr[0] && !seen_hi) begin
            seen_hi = 1; hi_addr = sram_addr; hi_data = s_do; hi_lanes = {ub_n, lb_n};
         end
         @(negedge clk);
      end
      done_rd = rddata;
      rd = 0; wr = 0;
   endtask

   initial begin
      int   n2, lo2, hi2;
      logic found;
      mem2[8] = 16'hBEEF;
      mem2[9] = 16'hFACE;

      #12;
      check("rst_strobes", {27'd0, ce_n, oe_n, we_n, lb_n, ub_n}, 32'h1F);
      check("rst_oe_stall", {30'd0, s_oe, stall}, 32'h0);
      check("rst_addr_data", {sram_addr[15:0], s_do}, 32'h0);
      check("rst_rddata", rddata, 32'h0);
      check("rst_rddata2", rddata2, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Word write.
      access(1'b1, 32'h8000_0010, 4'b1111, 32'h1234_5678);
      check("ww_stall", n_stall, 5);
      check("ww_ce", n_ce, 4);
      check("ww_we", n_we, 2);
      check("ww_lo", {6'd0, lo_addr[7:0], lo_data, lo_lanes}, {6'd0, 8'h08, 16'h5678, 2'b00});
      check("ww_hi", {6'd0, hi_addr[7:0], hi_data, hi_lanes}, {6'd0, 8'h09, 16'h1234, 2'b00});

      // Word read back.
      access(1'b0, 32'h8000_0010, 4'b1111, 32'h0);
      check("wr_data", done_rd, 32'h1234_5678);
      check("wr_stall", n_stall, 5);
      check("wr_oe", n_oe, 4);
      check("wr_we", n_we, 0);

      // Byte write into lane 2 only; upper byte of halfword 9 is preserved.
      access(1'b1, 32'h8000_0010, 4'b0100, 32'h00AB_0000);
      check("bw_stall", n_stall, 3);
      check("bw_ce", n_ce, 2);
      check("bw_lo_seen", {31'd0, seen_lo}, 32'h0);
      check("bw_hi", {6'd0, hi_addr[7:0], hi_data, hi_lanes}, {6'd0, 8'h09, 16'h00AB, 2'b10});
      access(1'b0, 32'h8000_0010, 4'b1111, 32'h0);
      check("bw_read", done_rd, 32'h12AB_5678);

      // High-half read: skipped low half reads as zero.
      access(1'b0, 32'h8000_0010, 4'b1100, 32'h0);
      check("hr_data", done_rd, 32'h12AB_0000);
      check("hr_stall", n_stall, 3);

      // Empty byteenable: single stall cycle, no SRAM activity, data held.
      access(1'b0, 32'h8000_0010, 4'b0000, 32'h0);
      check("be0_stall", n_stall, 1);
      check("be0_ce", n_ce, 0);
      check("be0_data", done_rd, 32'h12AB_0000);

      // Reset during HI phase of a write.
      @(negedge clk);
      addr = 32'h8000_0020; be = 4'b1111; wdata = 32'hCAFE_BABE; wr = 1;
      found = 0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (!ce_n && sram_addr[0]) begin found = 1; break; end
         @(negedge clk);
      end
      check("rst_found_hi", {31'd0, found}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_pins", {27'd0, ce_n, we_n, oe_n, s_oe, stall}, {27'd0, 5'b11100});
      wr = 0;
      #2 rst_n = 1'b1;
      access(1'b0, 32'h8000_0020, 4'b0011, 32'h0);
      check("post_rst_lo", done_rd, 32'h0000_BABE);
      check("post_rst_stall", n_stall, 3);

      // WAIT_CYCLES=3 instance, word read.
      @(negedge clk);
      addr = 32'h8000_0010; be = 4'b1111; rd2 = 1;
      n2 = 0; lo2 = 0; hi2 = 0;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (!stall2) break;
         n2++;
         if (!ce2_n && !sram2_addr[0]) lo2++;
         if (!ce2_n && sram2_addr[0]) hi2++;
         @(negedge clk);
      end
      check("w3_data", rddata2, 32'hFACE_BEEF);
      rd2 = 0;
      check("w3_stall", n2, 9);
      check("w3_lo_len", lo2, 4);
      check("w3_hi_len", hi2, 4);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
